// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps one read outstanding to instruction
// memory, and feeds the IF/ID register with stall hold buffer and redirect squash.
module fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_next_sel,
    input  logic [31:0] branch_jump_addr,
    input  logic        stall_IF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_ID,
    output logic [31:0] instr_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] pcPlus4_ID
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_req_pc, w_pc_nxt, w_target;
    logic        r_hold_valid;
    logic [31:0] r_hold_instr, r_hold_pc;
    logic        r_valid;
    logic [31:0] r_instr, r_pc_id, r_pcp4;
    logic        w_ret, w_accept;

    assign w_target  = {branch_jump_addr[31:2], 2'b00};
    assign w_ret     = (r_state == S_WAIT) && imem_rvalid;
    // A new request may overlap the returning one only if that data can go straight to IF/ID.
    assign imem_req  = !rst && !pc_next_sel &&
                       (((r_state == S_FETCH) && !r_hold_valid) || (w_ret && !stall_IF));
    assign w_accept  = imem_req && imem_gnt;
    assign imem_addr = r_pc;

    assign valid_ID   = r_valid;
    assign instr_ID   = r_valid ? r_instr : NOP_INSTR;
    assign pc_ID      = r_pc_id;
    assign pcPlus4_ID = r_pcp4;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (pc_next_sel)
            w_pc_nxt = w_target;
        else if (w_accept)
            w_pc_nxt = r_pc + 32'd4;
        case (r_state)
            S_FETCH: if (w_accept) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid)
                    w_state_nxt = w_accept ? S_WAIT : S_FETCH;
                else if (pc_next_sel)
                    w_state_nxt = S_DROP;
            end
            S_DROP: if (imem_rvalid) w_state_nxt = S_FETCH;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_req_pc     <= 32'd0;
            r_hold_valid <= 1'b0;
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
            r_valid      <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_pc_id      <= 32'd0;
            r_pcp4       <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_accept)
                r_req_pc <= r_pc;

            if (pc_next_sel) begin
                r_hold_valid <= 1'b0;
            end else if (w_ret && stall_IF) begin
                r_hold_valid <= 1'b1;
                r_hold_instr <= imem_rdata;
                r_hold_pc    <= r_req_pc;
            end else if (!stall_IF) begin
                r_hold_valid <= 1'b0;
            end

            // Flush beats stall; the hold buffer drains before any fresh return.
            if (pc_next_sel) begin
                r_valid <= 1'b0;
            end else if (!stall_IF) begin
                if (r_hold_valid) begin
                    r_valid <= 1'b1;
                    r_instr <= r_hold_instr;
                    r_pc_id <= r_hold_pc;
                    r_pcp4  <= r_hold_pc + 32'd4;
                end else if (w_ret) begin
                    r_valid <= 1'b1;
                    r_instr <= imem_rdata;
                    r_pc_id <= r_req_pc;
                    r_pcp4  <= r_req_pc + 32'd4;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the RISC-V pipeline. It owns the program counter, issues one-outstanding-request reads to instruction memory, and loads the IF/ID pipeline register consumed by decode. It is the receiving end of the execute stage's redirect interface (`pc_next_sel` / `branch_jump_addr`). It honours hazard-unit stalls through a one-entry hold buffer and squashes wrong-path fetches on redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013 (addi x0,x0,0): value of `instr_ID` whenever `valid_ID`=0.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `pc_next_sel`  in  1  redirect request from execute (taken branch or jump).
- `branch_jump_addr`  in  32  redirect target from execute.
- `stall_IF`  in  1  hazard-unit hold of the IF/ID register.
- `imem_req`  out  1  read request valid (combinational).
- `imem_addr`  out  32  read address; equals PC register.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  32  read data.
- `valid_ID`  out  1  IF/ID register holds a real instruction.
- `instr_ID`  out  32  IF/ID instruction.
- `pc_ID`  out  32  address of `instr_ID`.
- `pcPlus4_ID`  out  32  `pc_ID`+4, modulo 2^32.

## Operation
- Registers: `pc` (next fetch address), `req_pc` (address of the outstanding request), FSM state, hold buffer (`hold_valid`, `hold_instr`, `hold_pc`), and IF/ID outputs.
- FSM states:
  - FETCH: no request outstanding.
  - WAIT: request accepted, awaiting data.
  - DROP: request accepted but squashed; its data is discarded.
- `imem_req` = !rst & !pc_next_sel & ((FETCH & !hold_valid) | (WAIT & imem_rvalid & !stall_IF)).
- Request accepted (`imem_req & imem_gnt`): `req_pc`<=`pc`, `pc`<=`pc`+4 (wraps 32'hFFFF_FFFC -> 0), next state WAIT.
- FETCH:
  - with `pc_next_sel`: `pc`<=target, stay FETCH.
  - request not accepted: stay FETCH.
- WAIT:
  - `rvalid` & !`pc_next_sel`: the instruction (`imem_rdata`, `req_pc`) goes to IF/ID if !`stall_IF`, else into the hold buffer. Next state is WAIT if a new request was accepted the same cycle, else FETCH.
  - `pc_next_sel` & `rvalid`: data discarded, `pc`<=target, next FETCH.
  - `pc_next_sel` & !`rvalid`: `pc`<=target, next DROP.
- DROP:
  - `rvalid`: data discarded, next FETCH.
  - `pc_next_sel`: `pc`<=target, stay DROP.
  - Both in the same cycle: `pc`<=target, next FETCH.
- Redirect target: `pc`<={`branch_jump_addr`[31:2],2'b00}.
- IF/ID update, in priority order:
  1. `pc_next_sel`: `valid_ID`<=0, `hold_valid`<=0 (flush has priority over stall).
  2. `stall_IF`: hold all IF/ID outputs.
  3. `hold_valid`: load from the hold buffer, `hold_valid`<=0.
  4. WAIT & `rvalid`: load the returned instruction.
  5. Otherwise: `valid_ID`<=0 (bubble).
- `valid_ID`=0 forces `instr_ID`=`NOP_INSTR`. `pcPlus4_ID` is recomputed from `pc_ID` on every load.
- No request is issued while `hold_valid`=1, so the hold buffer never overflows.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state FETCH, `hold_valid`=0.
  - `valid_ID`=0, `instr_ID`=`NOP_INSTR`, `pc_ID`=0, `pcPlus4_ID`=0.
  - `imem_req`=0 during every cycle in which `rst`=1.
- First request: the first cycle after `rst` falls, with `imem_addr`=`RESET_PC`.
- Latency: gnt in cycle N and rvalid in cycle N+k (k>=1) gives `valid_ID`=1 in cycle N+k+1.
- Throughput: with gnt always 1 and k=1, one instruction per cycle after the first.
- Redirect in cycle N:
  - `imem_req`=0 in cycle N.
  - First request at the target in N+1, unless state is DROP, which waits for the stale `rvalid`.
  - `valid_ID`=0 in N+1.
- Stall while data returns: instruction parked in the hold buffer; delivered the first cycle `stall_IF`=0.
- `rst` mid-transaction: state returns to FETCH, and any later `rvalid` for the old request while in FETCH is ignored. The memory must drop outstanding requests on the same `rst`.

## Test plan
- Reset, `RESET_PC`=0x100, gnt=1, rvalid one cycle after gnt -> `pc_ID`=0x100, 0x104, 0x108 on consecutive cycles, each with `valid_ID`=1 and `pcPlus4_ID`=`pc_ID`+4.
- `stall_IF`=1 for 3 cycles while data for 0x108 returns -> `instr_ID`/`pc_ID` frozen at 0x104 and no `imem_req` while held. 0x108 appears the cycle after the stall releases.
- `pc_next_sel`=1, target 0x2002, while in WAIT with no rvalid -> state DROP, stale data discarded, next request `imem_addr`=0x2000, `valid_ID`=0 the cycle after the redirect.
- Redirect and `stall_IF` in the same cycle with the hold buffer full -> `valid_ID`=0, `hold_valid`=0, next fetch at the target.
- `pc`=0xFFFF_FFFC accepted -> `pc` wraps to 0x0, `pcPlus4_ID`=0x0.
- `rst` asserted in WAIT with rvalid 2 cycles later -> `valid_ID` stays 0 and the first post-reset request is at `RESET_PC`.
